cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 20 ++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-bus handshake between the functional units and the CDB arbiter.
interface cdb_arbiter_if;
  logic [7:0] req;
  logic [7:0] lock;
  logic       cdb_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       cdb_valid;
  logic [7:0] done;

  modport master (
    output req, lock, cdb_ready,
    input  sel, gnt, cdb_valid, done
  );

  modport slave (
    input  req, lock, cdb_ready,
    output sel, gnt, cdb_valid, done
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter for 8 functional units, with optional
// locked bursts of up to MAX_LOCK consecutive transfers per owner.
module cdb_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [2:0] LOCK_LIM = 3'(MAX_LOCK - 1);

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] lock_cnt_q, lock_cnt_d;

  logic [7:0] rel_req;
  logic [2:0] rel_ptr;
  logic [3:0] idle_pick, rel_pick;
  logic       transfer;

  // Returns {found, index} of the first set bit scanning p, p+1, ... with
  // natural 3-bit wrap; scanning downward lets the nearest hit overwrite.
  function automatic logic [3:0] rr_pick(input logic [7:0] v, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] idx;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign transfer  = (state_q == GRANT) && bus.cdb_ready;
  assign rel_ptr   = sel_q + 3'd1;
  assign rel_req   = bus.req & ~gnt_q;
  assign idle_pick = rr_pick(bus.req, ptr_q);
  assign rel_pick  = rr_pick(rel_req, rel_ptr);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (idle_pick[3]) begin
          state_d = GRANT;
          sel_d   = idle_pick[2:0];
          gnt_d   = 8'b1 << idle_pick[2:0];
        end
      end
      GRANT: begin
        if (transfer) begin
          if (bus.lock[sel_q] && bus.req[sel_q] && (lock_cnt_q < LOCK_LIM)) begin
            lock_cnt_d = lock_cnt_q + 3'd1;
          end else begin
            lock_cnt_d = '0;
            ptr_d      = rel_ptr;
            if (rel_pick[3]) begin
              sel_d = rel_pick[2:0];
              gnt_d = 8'b1 << rel_pick[2:0];
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.cdb_valid = (state_q == GRANT);
  assign bus.done      = gnt_q & {8{transfer}};

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction model.
module tb_cdb_arbiter;

  localparam int MAX_LOCK = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: current owner (-1 when idle), priority start, transfers
  // made by the owner in its current tenure, last reported select.
  int   m_owner, m_ptr, m_burst, m_sel;
  int   wait_cnt [8];
  logic served   [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_burst = 0;
    m_sel   = 0;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] l, input logic rd);
    int mx;
    logic [7:0] rest;
    mx = 0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = pick(r, m_ptr);
        m_sel   = m_owner;
      end
    end else if (rd) begin
      for (int i = 0; i < 8; i++) begin
        if (i == m_owner || !r[i]) wait_cnt[i] = 0;
        else begin
          wait_cnt[i]++;
          if (wait_cnt[i] > mx) mx = wait_cnt[i];
        end
      end
      check("fairness", 32'(mx <= 8 * MAX_LOCK), 32'd1);
      m_burst++;
      if (!(l[m_owner] && r[m_owner] && m_burst < MAX_LOCK)) begin
        rest          = r;
        rest[m_owner] = 1'b0;
        m_ptr         = (m_owner + 1) % 8;
        m_burst       = 0;
        m_owner       = pick(rest, m_ptr);
        if (m_owner >= 0) m_sel = m_owner;
      end
    end
  endtask

  task automatic compare();
    logic [7:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    check("gnt",    32'(bus.gnt),       32'(e));
    check("sel",    32'(bus.sel),       32'(m_sel));
    check("valid",  32'(bus.cdb_valid), 32'(m_owner >= 0));
    check("done",   32'(bus.done),      32'(bus.cdb_ready ? e : 8'h00));
    check("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
  endtask

  task automatic apply(input logic [7:0] r, input logic [7:0] l, input logic rd);
    bus.req       = r;
    bus.lock      = l;
    bus.cdb_ready = rd;
    #1;
    compare();
  endtask

  task automatic advance();
    int x;
    x = (m_owner >= 0 && bus.cdb_ready) ? m_owner : -1;
    @(posedge clk);
    model_step(bus.req, bus.lock, bus.cdb_ready);
    if (x >= 0) served[x] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] nr;
    reset         = 1'b0;
    bus.req       = '0;
    bus.lock      = '0;
    bus.cdb_ready = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) served[i] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",   32'(bus.gnt),       32'h0);
    check("rst_valid", 32'(bus.cdb_valid), 32'h0);
    check("rst_sel",   32'(bus.sel),       32'h0);
    check("rst_done",  32'(bus.done),      32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Two requesters from reset: unit 0 first, then unit 7, then idle.
    apply(8'h81, 8'h00, 1'b1);
    check("r25_idle", 32'(bus.cdb_valid), 32'h0);
    advance();
    apply(8'h81, 8'h00, 1'b1);
    check("r25_gnt0",  32'(bus.gnt),  32'h01);
    check("r25_sel0",  32'(bus.sel),  32'h0);
    check("r25_done0", 32'(bus.done), 32'h01);
    advance();
    apply(8'h80, 8'h00, 1'b1);
    check("r25_gnt7", 32'(bus.gnt), 32'h80);
    check("r25_sel7", 32'(bus.sel), 32'h7);
    advance();
    apply(8'h00, 8'h00, 1'b1);
    check("r25_end_valid", 32'(bus.cdb_valid), 32'h0);
    check("r25_end_sel",   32'(bus.sel),       32'h7);
    advance();

    // All units requesting: strict rotation with no idle bubble.
    apply(8'hFF, 8'h00, 1'b1);
    advance();
    for (int k = 0; k < 9; k++) begin
      apply(8'hFF, 8'h00, 1'b1);
      check("r26_sel",   32'(bus.sel),       32'(k % 8));
      check("r26_valid", 32'(bus.cdb_valid), 32'h1);
      advance();
    end
    apply(8'h02, 8'h00, 1'b1);
    check("r26_tail", 32'(bus.gnt), 32'h02);
    advance();

    // Stalled owner keeps the bus while requests change underneath it.
    apply(8'h04, 8'h00, 1'b1);
    advance();
    for (int k = 0; k < 5; k++) begin
      apply((k == 0) ? 8'h04 : 8'h10, 8'h00, 1'b0);
      check("r27_gnt",  32'(bus.gnt),  32'h04);
      check("r27_sel",  32'(bus.sel),  32'h2);
      check("r27_done", 32'(bus.done), 32'h00);
      advance();
    end
    apply(8'h10, 8'h00, 1'b1);
    check("r27_xfer", 32'(bus.done), 32'h04);
    advance();
    apply(8'h10, 8'h00, 1'b1);
    check("r27_next", 32'(bus.gnt), 32'h10);
    advance();
    apply(8'h00, 8'h00, 1'b1);
    advance();

    // Locked burst: unit 0 holds for MAX_LOCK transfers, then unit 3.
    apply(8'h09, 8'h01, 1'b1);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(8'h09, 8'h01, 1'b1);
      check("r28_lock", 32'(bus.gnt), 32'h01);
      advance();
    end
    apply(8'h08, 8'h00, 1'b1);
    check("r28_gnt3", 32'(bus.gnt), 32'h08);
    check("r28_sel3", 32'(bus.sel), 32'h3);
    advance();
    apply(8'h00, 8'h00, 1'b1);
    advance();

    // Asynchronous reset in the middle of a stalled grant.
    apply(8'h40, 8'h00, 1'b0);
    advance();
    apply(8'h40, 8'h00, 1'b0);
    check("r29_pre", 32'(bus.gnt), 32'h40);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("r29_gnt",   32'(bus.gnt),       32'h00);
    check("r29_valid", 32'(bus.cdb_valid), 32'h0);
    check("r29_done",  32'(bus.done),      32'h00);
    compare();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(8'h20, 8'h00, 1'b1);
    advance();
    apply(8'h20, 8'h00, 1'b1);
    check("r29_after", 32'(bus.gnt), 32'h20);
    advance();

    // Random traffic; a requester only drops after it has been served.
    apply(8'h00, 8'h00, 1'b0);
    advance();
    for (int i = 0; i < 8; i++) served[i] = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      nr = bus.req;
      for (int i = 0; i < 8; i++) begin
        if (!nr[i]) nr[i] = ($urandom_range(2) == 0);
        else if (served[i]) begin
          nr[i]     = $urandom_range(1);
          served[i] = 1'b0;
        end
      end
      apply(nr, 8'($urandom), $urandom_range(3) != 0);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
